// File: rtl/nbonacci_pkg.sv
// Shared definitions for the N-bonacci sequence generator.
// Holds the two-state control enum, the upper bound on ORDER and the helper
// that sizes the full-precision sum of ORDER terms of WIDTH bits each.
package nbonacci_pkg;

  localparam int ORDER_MAX = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width needed to hold the exact sum of `order` unsigned `width`-bit terms.
  function automatic int sum_width(input int width, input int order);
    return width + $clog2(order);
  endfunction

endpackage

// File: rtl/nbonacci_seq_multi_adder.sv
// multi_adder: combinational N-input unsigned adder with a full-precision sum.
// Ports: in_i packs operand k at [k*WIDTH +: WIDTH]; sum_o is WIDTH+$clog2(N)
// bits wide, so the result never loses carries.
module multi_adder
  import nbonacci_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 32
) (
  input  logic [N*WIDTH-1:0]               in_i,
  output logic [sum_width(WIDTH, N)-1:0]   sum_o
);

  localparam int SW = sum_width(WIDTH, N);

  // Written as a linear accumulation; synthesis is free to rebalance it
  // into a tree since every operand is available at the same time.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o = sum_o + SW'(in_i[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/nbonacci_seq.sv
// nbonacci_seq: streams a programmable-length sequence in which every term is
// the sum of the previous ORDER terms, over a valid/ready link.
// Ports: clk/rst (sync, active-high); start, seed_i, num_i load a run;
// out_valid/out_ready/out_data/out_last form the stream; busy_o marks RUN;
// ovf_o is a sticky flag for any computed sum exceeding 2^WIDTH-1.
// Build option: define NBONACCI_SAT_EN to clamp overflowed sums to all-ones
// instead of wrapping modulo 2^WIDTH.
module nbonacci_seq
  import nbonacci_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ORDER*WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0]       num_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy_o,
  output logic                   ovf_o
);

  localparam int SUM_W = sum_width(WIDTH, ORDER);

  if (ORDER < 2 || ORDER > ORDER_MAX) begin : g_bad_order
    $error("nbonacci_seq: ORDER must lie in 2..ORDER_MAX");
  end

  state_e                 state_q, state_d;
  logic [ORDER*WIDTH-1:0] win_q, win_d;   // w[0] (oldest) in the low WIDTH bits
  logic [CNT_W-1:0]       cnt_q, cnt_d;   // terms still to be accepted
  logic                   ovf_q, ovf_d;

  logic [SUM_W-1:0]       sum;
  logic                   sum_ovf;
  logic [WIDTH-1:0]       next_term;

  multi_adder #(
    .N     (ORDER),
    .WIDTH (WIDTH)
  ) u_multi_adder (
    .in_i  (win_q),
    .sum_o (sum)
  );

  assign sum_ovf = |sum[SUM_W-1:WIDTH];

`ifdef NBONACCI_SAT_EN
  // Once a term saturates, every later window contains all-ones, so the
  // stream stays pinned at all-ones for the rest of the run.
  assign next_term = sum_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign next_term = sum[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // Any accepted start clears the flag, even a zero-length one.
        if (start) begin
          ovf_d = 1'b0;
          if (num_i != '0) begin
            state_d = RUN;
            win_d   = seed_i;
            cnt_d   = num_i;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          // Shift the window down one term and append the new sum on top.
          // The sum is formed even for the final term, so it can still
          // raise the overflow flag.
          win_d = {next_term, win_q[ORDER*WIDTH-1:WIDTH]};
          cnt_d = cnt_q - CNT_W'(1);
          ovf_d = ovf_q | sum_ovf;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy_o    = (state_q == RUN);
  assign out_last  = (state_q == RUN) && (cnt_q == CNT_W'(1));
  assign out_data  = win_q[WIDTH-1:0];
  assign ovf_o     = ovf_q;

endmodule
